// File: rtl/noise_collector.sv
// Noise collector: XOR-folds raw noise samples to bits, packs them into words behind a
// one-entry valid/ready buffer, and runs a repetition-count health test. Optional
// von Neumann debiaser enabled by defining NOISE_COLLECTOR_VNEUMANN_EN.
module noise_collector #(
    parameter int SAMPLE_W   = 4,
    parameter int WORD_W     = 32,
    parameter int RCT_CUTOFF = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] noise_in,
    input  logic                noise_vld,
    output logic [WORD_W-1:0]   word_out,
    output logic                word_vld,
    input  logic                word_rdy,
    output logic                rct_fail,
    output logic                ovf,
    input  logic                clr_err,
    output logic                busy
);
    // Handshake: a word transfers on any cycle where word_vld and word_rdy are both high;
    // word_out holds steady while word_vld=1 and word_rdy=0.
    localparam int CNT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {IDLE, RUN, FAIL} state_t;

    state_t              state;
    logic [WORD_W-1:0]   shreg;
    logic [CNT_W-1:0]    bit_cnt;
    logic [7:0]          rep_cnt;
    logic [SAMPLE_W-1:0] last_sample;

    logic                accept;
    logic                raw_bit;
    logic                shift_en;
    logic                shift_bit;
    logic [7:0]          rep_next;
    logic                trip;
    logic                word_done;
    logic [WORD_W-1:0]   next_word;
    logic                buf_free;

`ifdef NOISE_COLLECTOR_VNEUMANN_EN
    logic vn_phase;
    logic vn_bit;
`endif

    always_comb begin
        accept  = (state == RUN) && en && noise_vld;
        raw_bit = ^noise_in;
        // rep_cnt==0 marks the first sample after IDLE/FAIL, which always restarts the run
        if ((rep_cnt != 8'd0) && (noise_in == last_sample))
            rep_next = (rep_cnt == 8'hFF) ? rep_cnt : rep_cnt + 8'd1;
        else
            rep_next = 8'd1;
        trip = accept && (rep_next == 8'(RCT_CUTOFF));
`ifdef NOISE_COLLECTOR_VNEUMANN_EN
        // Second bit of a differing pair emits the first bit: 10 -> 1, 01 -> 0
        shift_en  = accept && vn_phase && (vn_bit != raw_bit);
        shift_bit = vn_bit;
`else
        shift_en  = accept;
        shift_bit = raw_bit;
`endif
        word_done = shift_en && (bit_cnt == CNT_W'(WORD_W - 1));
        next_word = {shreg[WORD_W-2:0], shift_bit};
        buf_free  = !word_vld || word_rdy;
    end

    assign busy = (bit_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= 8'd0;
            last_sample <= '0;
            word_out    <= '0;
            word_vld    <= 1'b0;
            rct_fail    <= 1'b0;
            ovf         <= 1'b0;
`ifdef NOISE_COLLECTOR_VNEUMANN_EN
            vn_phase    <= 1'b0;
            vn_bit      <= 1'b0;
`endif
        end else begin
            if (word_vld && word_rdy)
                word_vld <= 1'b0;
            if (clr_err) begin
                rct_fail <= 1'b0;
                ovf      <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (en)
                        state <= RUN;
                end
                RUN: begin
                    if (!en) begin
                        state   <= IDLE;
                        shreg   <= '0;
                        bit_cnt <= '0;
                        rep_cnt <= 8'd0;
`ifdef NOISE_COLLECTOR_VNEUMANN_EN
                        vn_phase <= 1'b0;
`endif
                    end else if (trip) begin
                        // Failure beats a simultaneous clr_err and any word this sample completes
                        state       <= FAIL;
                        rct_fail    <= 1'b1;
                        word_vld    <= 1'b0;
                        shreg       <= '0;
                        bit_cnt     <= '0;
                        rep_cnt     <= 8'd0;
                        last_sample <= noise_in;
`ifdef NOISE_COLLECTOR_VNEUMANN_EN
                        vn_phase    <= 1'b0;
`endif
                    end else if (accept) begin
                        rep_cnt     <= rep_next;
                        last_sample <= noise_in;
`ifdef NOISE_COLLECTOR_VNEUMANN_EN
                        vn_phase <= !vn_phase;
                        if (!vn_phase)
                            vn_bit <= raw_bit;
`endif
                        if (shift_en) begin
                            shreg <= next_word;
                            if (word_done) begin
                                bit_cnt <= '0;
                                if (buf_free) begin
                                    word_out <= next_word;
                                    word_vld <= 1'b1;
                                end else begin
                                    ovf <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                FAIL: begin
                    if (clr_err)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_noise_collector.sv
// Directed self-checking bench for noise_collector; inputs change and outputs are
// sampled on the falling clock edge.
module tb_noise_collector;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  noise_in;
    logic        noise_vld;
    logic [31:0] word_out;
    logic        word_vld;
    logic        word_rdy;
    logic        rct_fail;
    logic        ovf;
    logic        clr_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    noise_collector #(.SAMPLE_W(4), .WORD_W(32), .RCT_CUTOFF(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .noise_in(noise_in), .noise_vld(noise_vld),
        .word_out(word_out), .word_vld(word_vld), .word_rdy(word_rdy),
        .rct_fail(rct_fail), .ovf(ovf), .clr_err(clr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Called on a falling edge; returns on the next falling edge after the sample is taken.
    task automatic drive_sample(input logic [3:0] s);
        noise_in  = s;
        noise_vld = 1'b1;
        @(negedge clk);
        noise_vld = 1'b0;
    endtask

    task automatic send_alt(input int n, input logic [3:0] even_s, input logic [3:0] odd_s);
        for (int i = 0; i < n; i++)
            drive_sample((i % 2 == 0) ? even_s : odd_s);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; noise_in = 4'h0; noise_vld = 1'b0; word_rdy = 1'b0; clr_err = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (word_out !== 32'h0) begin failures++; $display("FAIL reset_word_out: got %h want %h", word_out, 32'h0); end
        checks++; if (word_vld !== 1'b0) begin failures++; $display("FAIL reset_word_vld: got %b want 0", word_vld); end
        checks++; if (rct_fail !== 1'b0) begin failures++; $display("FAIL reset_rct_fail: got %b want 0", rct_fail); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alternating();
        en = 1'b1; word_rdy = 1'b1;
        @(negedge clk);
        send_alt(31, 4'h1, 4'h0);
        checks++; if (word_vld !== 1'b0) begin failures++; $display("FAIL alt_vld_early: got %b want 0", word_vld); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL alt_busy: got %b want 1", busy); end
        drive_sample(4'h0);
        checks++; if (word_vld !== 1'b1) begin failures++; $display("FAIL alt_vld: got %b want 1", word_vld); end
        checks++; if (word_out !== 32'hAAAAAAAA) begin failures++; $display("FAIL alt_word: got %h want %h", word_out, 32'hAAAAAAAA); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL alt_busy_wrap: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (word_vld !== 1'b0) begin failures++; $display("FAIL alt_vld_one_cycle: got %b want 0", word_vld); end
        checks++; if (rct_fail !== 1'b0) begin failures++; $display("FAIL alt_rct: got %b want 0", rct_fail); end
    endtask

    task automatic test_health();
        word_rdy = 1'b0;
        send_alt(32, 4'h1, 4'h0);
        checks++; if (word_vld !== 1'b1) begin failures++; $display("FAIL rct_pre_vld: got %b want 1", word_vld); end
        repeat (7) drive_sample(4'h5);
        drive_sample(4'h6);
        checks++; if (rct_fail !== 1'b0) begin failures++; $display("FAIL rct_seven: got %b want 0", rct_fail); end
        checks++; if (word_vld !== 1'b1) begin failures++; $display("FAIL rct_seven_vld: got %b want 1", word_vld); end
        repeat (7) drive_sample(4'h5);
        checks++; if (rct_fail !== 1'b0) begin failures++; $display("FAIL rct_seventh: got %b want 0", rct_fail); end
        drive_sample(4'h5);
        checks++; if (rct_fail !== 1'b1) begin failures++; $display("FAIL rct_eighth: got %b want 1", rct_fail); end
        checks++; if (word_vld !== 1'b0) begin failures++; $display("FAIL rct_flush: got %b want 0", word_vld); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rct_busy: got %b want 0", busy); end
        word_rdy = 1'b1;
        send_alt(4, 4'h1, 4'h0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fail_no_accept: got %b want 0", busy); end
        checks++; if (rct_fail !== 1'b1) begin failures++; $display("FAIL fail_sticky: got %b want 1", rct_fail); end
        pulse_clr();
        checks++; if (rct_fail !== 1'b0) begin failures++; $display("FAIL clr_rct: got %b want 0", rct_fail); end
        drive_sample(4'h1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_to_idle: got %b want 0", busy); end
        drive_sample(4'h0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL idle_to_run: got %b want 1", busy); end
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        word_rdy = 1'b0;
        send_alt(32, 4'h1, 4'h0);
        checks++; if (word_vld !== 1'b1) begin failures++; $display("FAIL ovf_first_vld: got %b want 1", word_vld); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b want 0", ovf); end
        send_alt(32, 4'h1, 4'h0);
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", ovf); end
        checks++; if (word_out !== 32'hAAAAAAAA) begin failures++; $display("FAIL ovf_word_held: got %h want %h", word_out, 32'hAAAAAAAA); end
        checks++; if (word_vld !== 1'b1) begin failures++; $display("FAIL ovf_vld_held: got %b want 1", word_vld); end
        word_rdy = 1'b1;
        @(negedge clk);
        word_rdy = 1'b0;
        checks++; if (word_vld !== 1'b0) begin failures++; $display("FAIL ovf_drain: got %b want 0", word_vld); end
        pulse_clr();
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clr: got %b want 0", ovf); end
    endtask

    task automatic test_back_to_back();
        word_rdy = 1'b0;
        send_alt(32, 4'h1, 4'h0);
        send_alt(31, 4'h1, 4'h7);
        checks++; if (word_out !== 32'hAAAAAAAA) begin failures++; $display("FAIL b2b_hold: got %h want %h", word_out, 32'hAAAAAAAA); end
        word_rdy = 1'b1;
        drive_sample(4'h7);
        checks++; if (word_vld !== 1'b1) begin failures++; $display("FAIL b2b_vld: got %b want 1", word_vld); end
        checks++; if (word_out !== 32'hFFFFFFFF) begin failures++; $display("FAIL b2b_word: got %h want %h", word_out, 32'hFFFFFFFF); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
        @(negedge clk);
        checks++; if (word_vld !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %b want 0", word_vld); end
        word_rdy = 1'b0;
    endtask

    task automatic test_enable_drop();
        send_alt(10, 4'h1, 4'h7);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL en_partial_busy: got %b want 1", busy); end
        en = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL en_low_busy: got %b want 0", busy); end
        drive_sample(4'h1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL en_low_no_accept: got %b want 0", busy); end
        en = 1'b1;
        @(negedge clk);
        send_alt(31, 4'h1, 4'h0);
        checks++; if (word_vld !== 1'b0) begin failures++; $display("FAIL en_no_early_word: got %b want 0", word_vld); end
        drive_sample(4'h0);
        checks++; if (word_vld !== 1'b1) begin failures++; $display("FAIL en_vld: got %b want 1", word_vld); end
        checks++; if (word_out !== 32'hAAAAAAAA) begin failures++; $display("FAIL en_word: got %h want %h", word_out, 32'hAAAAAAAA); end
    endtask

    task automatic test_async_reset();
        send_alt(17, 4'h1, 4'h0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ar_pre_busy: got %b want 1", busy); end
        checks++; if (word_vld !== 1'b1) begin failures++; $display("FAIL ar_pre_vld: got %b want 1", word_vld); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (word_out !== 32'h0) begin failures++; $display("FAIL ar_word: got %h want %h", word_out, 32'h0); end
        checks++; if (word_vld !== 1'b0) begin failures++; $display("FAIL ar_vld: got %b want 0", word_vld); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_busy: got %b want 0", busy); end
        checks++; if ({rct_fail, ovf} !== 2'b00) begin failures++; $display("FAIL ar_flags: got %b want 00", {rct_fail, ovf}); end
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_debias();
        en = 1'b1; word_rdy = 1'b1;
        @(negedge clk);
        send_alt(63, 4'h1, 4'h0);
        checks++; if (word_vld !== 1'b0) begin failures++; $display("FAIL vn_early: got %b want 0", word_vld); end
        drive_sample(4'h0);
        checks++; if (word_vld !== 1'b1) begin failures++; $display("FAIL vn_vld: got %b want 1", word_vld); end
        checks++; if (word_out !== 32'hFFFFFFFF) begin failures++; $display("FAIL vn_word: got %h want %h", word_out, 32'hFFFFFFFF); end
        @(negedge clk);
        word_rdy = 1'b0;
        send_alt(64, 4'h3, 4'h0);
        checks++; if (word_vld !== 1'b0) begin failures++; $display("FAIL vn_zero_pairs_vld: got %b want 0", word_vld); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL vn_zero_pairs_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
`ifdef NOISE_COLLECTOR_VNEUMANN_EN
        test_debias();
`else
        test_alternating();
        test_health();
        test_overflow();
        test_back_to_back();
        test_enable_drop();
        test_async_reset();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/noise_collector.md
Name: noise_collector

Overview:
- Consumer end of the ROSC noise path.
- Accepts the 4-bit summed noise samples produced by the LFSR noise generator and reduces each sample to one raw entropy bit by XOR-folding it.
- Packs the bits into WORD_W-bit words behind a single-entry output buffer with a valid/ready handshake.
- Runs a repetition-count health test on the raw samples. Sits between the noise source and the TRNG conditioning/register interface.

Parameters:
- SAMPLE_W, 4: width of the incoming noise sample.
- WORD_W, 32: output word width. Legal values are 8 to 64.
- RCT_CUTOFF, 8: number of consecutive identical samples that declares a failure. Legal values are 2 to 255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  collection enable, level-sensitive.
- noise_in  in  SAMPLE_W  noise sample.
- noise_vld  in  1  sample strobe; noise_in is consumed when noise_vld is high.
- word_out  out  WORD_W  collected word.
- word_vld  out  1  word_out is valid.
- word_rdy  in  1  downstream accepts the word.
- rct_fail  out  1  sticky repetition-count failure.
- ovf  out  1  sticky flag: a completed word was dropped.
- clr_err  in  1  single-cycle pulse; clears rct_fail and ovf.
- busy  out  1  a word is being collected (bit_cnt is non-zero).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - word_out=0, word_vld=0, rct_fail=0, ovf=0, busy=0.
  - Shift register = 0, bit_cnt = 0, rep_cnt = 0, last_sample = 0.
  - FSM = IDLE.
- FSM states:
  - IDLE: no samples are accepted. Moves to RUN when en=1.
  - RUN: every cycle with noise_vld=1, the sample is accepted.
    - Bit b = XOR of all noise_in bits.
    - shreg <= {shreg[WORD_W-2:0], b}; bit_cnt increments.
    - The first accepted bit ends up in word_out MSB.
  - RUN with en=0: moves to IDLE. The partial word is discarded (bit_cnt=0, shreg=0) and rep_cnt=0. Any word already in the output buffer is kept.
  - FAIL: entered from RUN when the health test trips.
    - No samples are accepted.
    - The output buffer is flushed: word_vld=0 next cycle, even if word_rdy is high in that cycle.
    - Partial word discarded; rct_fail=1.
    - A clr_err pulse moves FAIL to IDLE.
- Word completion: the sample that makes bit_cnt reach WORD_W completes the word.
  - If the buffer is empty, or is being drained that same cycle (word_vld and word_rdy both high), word_out is loaded from the completed word and word_vld=1 on the next cycle. Latency is 1 cycle from the completing sample.
  - Otherwise the completed word is dropped and ovf is set. word_out and word_vld are unchanged.
  - In both cases bit_cnt wraps to 0.
- Handshake:
  - A transfer occurs on any cycle with word_vld=1 and word_rdy=1.
  - word_vld drops next cycle unless a new word loads in the same cycle.
  - word_out is stable while word_vld=1 and word_rdy=0.
- Health test (RUN only, on accepted samples):
  - Sample equal to last_sample: rep_cnt increments, saturating at 255.
  - Otherwise rep_cnt=1; last_sample is updated on every accepted sample.
  - When rep_cnt reaches RCT_CUTOFF: the state is FAIL on the next cycle. If that same sample also completes a word, the word is discarded and is not loaded.
  - The very first sample after IDLE sets rep_cnt=1.
- Simultaneous events:
  - If clr_err arrives in the same cycle as a new failure, the failure wins and rct_fail stays 1.
  - clr_err clears ovf in any state.
- busy = (bit_cnt != 0).

Optional Feature:
- Macro: NOISE_COLLECTOR_VNEUMANN_EN.
- When defined, a von Neumann debiaser sits between the bit extraction and the shift register:
  - Bits are paired; the pair state is held in a 1-bit register plus a phase flag.
  - Pair 10 shifts in 1, pair 01 shifts in 0, pairs 00 and 11 shift in nothing.
  - The phase flag is reset on leaving RUN or entering FAIL.
  - The health test still runs on every raw sample.
- When not defined, every accepted sample shifts in one bit, with no pairing logic.

Test Plan:
- Alternating 32 samples, no debiaser: en=1, word_rdy=1, 32 samples alternating noise_in=4'h1 / 4'h0 → word_out=32'hAAAAAAAA, word_vld high for exactly 1 cycle, one cycle after the 32nd sample; rct_fail=0.
- Health-test boundary:
  - Seven samples of 4'h5 then 4'h6 → rct_fail stays 0.
  - Eight consecutive samples of 4'h5 → rct_fail=1 on the cycle after the 8th sample; word_vld=0; no further samples are accepted until a clr_err pulse, after which rct_fail=0 and the FSM is in IDLE.
- Overflow: word_rdy=0, 64 samples alternating 4'h1/4'h0 → word_out=32'hAAAAAAAA held stable, ovf=1 after the 64th sample. Then word_rdy=1 for one cycle → word_vld=0.
- Enable drop mid-word: en drops after 10 samples, then en=1 and 32 samples of the alternating pattern → first output is 32'hAAAAAAAA (the partial word is discarded); busy=0 while en is low.
- Asynchronous reset: rst_n asserted low mid-cycle while word_vld=1 and bit_cnt=17 → all outputs are 0 immediately, without waiting for a clock edge.
- Debiaser (NOISE_COLLECTOR_VNEUMANN_EN defined): 64 samples alternating 4'h1/4'h0 → word_out=32'hFFFFFFFF. Then 64 samples of alternating 4'h3/4'h0 (00 pairs) → no new word_vld.
